// File: rtl/jericalla_secuenciador.sv
// rtl/jericalla_secuenciador.sv - program sequencer for the jericalla_evolucion datapath
// Loads a small program memory, then issues each instruction for HOLD_CYCLES cycles.
module jericalla_secuenciador #(
  parameter int                 INSTR_W     = 19,
  parameter int                 DEPTH       = 16,
  parameter int                 ADDR_W      = 4,
  parameter int                 HOLD_CYCLES = 3,
  parameter logic [3:0]         HALT_OPCODE = 4'b1111,
  parameter logic [INSTR_W-1:0] IDLE_INSTR  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               stop_on_zf,
  input  logic               zf_in,
  output logic [INSTR_W-1:0] instruction,
  output logic               issue,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               halted_zf
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [INSTR_W-1:0] ir, ir_n;
  logic               issue_n, busy_n, done_n, halted_zf_n;
  logic [INSTR_W-1:0] fetch_word;
  logic               wr_en;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Program memory is only writable while the sequencer is parked.
  assign wr_en = load_we && (state == IDLE || state == DONE) && (int'(load_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_instr;
    end
  end

  assign fetch_word  = mem[pc];
  assign instruction = (state == EXEC) ? ir : IDLE_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      cnt       <= '0;
      ir        <= IDLE_INSTR;
      issue     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      halted_zf <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      cnt       <= cnt_n;
      ir        <= ir_n;
      issue     <= issue_n;
      busy      <= busy_n;
      done      <= done_n;
      halted_zf <= halted_zf_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    cnt_n       = cnt;
    ir_n        = ir;
    issue_n     = 1'b0;
    halted_zf_n = halted_zf;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = FETCH;
          pc_n        = '0;
          halted_zf_n = 1'b0;
        end
      end
      FETCH: begin
        if (fetch_word[INSTR_W-1 -: 4] == HALT_OPCODE) begin
          state_n = DONE;
        end else begin
          state_n = EXEC;
          ir_n    = fetch_word;
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          issue_n = 1'b1;
        end
      end
      EXEC: begin
        // zf_in only matters on the last hold cycle of each instruction.
        if (cnt == '0) begin
          if (stop_on_zf && zf_in) begin
            state_n     = DONE;
            halted_zf_n = 1'b1;
          end else if (pc == ADDR_W'(DEPTH - 1)) begin
            state_n = DONE;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = FETCH;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == FETCH) || (state_n == EXEC);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_jericalla_secuenciador.sv
// tb/tb_jericalla_secuenciador.sv - randomized self-checking bench for jericalla_secuenciador
module tb_jericalla_secuenciador;

  localparam logic [18:0] IDLE_W = 19'b0;
  localparam logic [18:0] ADD_W  = 19'b0010001000000000001;
  localparam logic [18:0] SUB_W  = 19'b0011001010000100010;
  localparam logic [18:0] AND_W  = 19'b0000011010101001011;

  logic        clk, reset, start, load_we, stop_on_zf, zf_in;
  logic [3:0]  load_addr;
  logic [18:0] load_instr;
  logic [18:0] instruction;
  logic        issue, busy, done, halted_zf;
  logic [3:0]  pc;

  jericalla_secuenciador dut (
    .clk(clk), .reset(reset), .start(start), .load_we(load_we),
    .load_addr(load_addr), .load_instr(load_instr), .stop_on_zf(stop_on_zf),
    .zf_in(zf_in), .instruction(instruction), .issue(issue), .pc(pc),
    .busy(busy), .done(done), .halted_zf(halted_zf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [18:0] m [0:15];
  bit          zf_sched [0:127];
  int          inj_we_cyc, inj_st_cyc;
  logic [18:0] inj_data;
  bit          same_we;
  logic [3:0]  same_addr;
  logic [18:0] same_data;
  int          n_checks, n_fail;

  function automatic logic [18:0] rand_word();
    return {4'($urandom_range(0, 14)), 15'($urandom)};
  endfunction

  task automatic clear_ctl();
    for (int i = 0; i < 128; i++) zf_sched[i] = 1'b0;
    inj_we_cyc = -1;
    inj_st_cyc = -1;
    same_we    = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [18:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_instr = d;
    m[a] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Expected per-cycle trace comes from the program rules: one fetch cycle,
  // then three hold cycles per instruction, stop on halt/zf/end of memory.
  task automatic run_check(input string name, input bit soz);
    logic [18:0] e_instr [0:79];
    bit          e_issue [0:79];
    logic [18:0] w;
    int          n, p, nissue, busy_seen, issue_seen;
    bit          ehz, fin;
    if (same_we) m[same_addr] = same_data;
    n = 1; p = 0; nissue = 0; ehz = 1'b0; fin = 1'b0;
    while (!fin) begin
      e_instr[n] = IDLE_W; e_issue[n] = 1'b0; n++;
      w = m[p];
      if (w[18:15] == 4'hF) begin
        fin = 1'b1;
      end else begin
        for (int h = 0; h < 3; h++) begin
          e_instr[n] = w; e_issue[n] = (h == 0); n++;
        end
        nissue++;
        if (soz && zf_sched[n-1]) begin ehz = 1'b1; fin = 1'b1; end
        else if (p == 15) fin = 1'b1;
        else p++;
      end
    end
    e_instr[n] = IDLE_W; e_issue[n] = 1'b0;
    busy_seen = 0; issue_seen = 0;
    stop_on_zf = soz;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      zf_in   = zf_sched[c];
      start   = (c == 0) || (c == inj_st_cyc);
      load_we = 1'b0;
      if (c == 0 && same_we) begin
        load_we = 1'b1; load_addr = same_addr; load_instr = same_data;
      end
      if (c == inj_we_cyc) begin
        load_we = 1'b1; load_addr = 4'd1; load_instr = inj_data;
      end
      if (c >= 1) begin
        busy_seen  += int'(busy);
        issue_seen += int'(issue);
        n_checks += 4;
        if (instruction !== e_instr[c]) begin
          n_fail++; $display("FAIL %s instr c=%0d got %h exp %h", name, c, instruction, e_instr[c]);
        end
        if (issue !== e_issue[c]) begin
          n_fail++; $display("FAIL %s issue c=%0d got %b exp %b", name, c, issue, e_issue[c]);
        end
        if (busy !== (c < n)) begin
          n_fail++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, (c < n));
        end
        if (done !== (c == n)) begin
          n_fail++; $display("FAIL %s done c=%0d got %b exp %b", name, c, done, (c == n));
        end
      end
    end
    start = 1'b0; load_we = 1'b0; zf_in = 1'b0;
    n_checks += 4;
    if (pc !== 4'(p)) begin
      n_fail++; $display("FAIL %s final_pc got %0d exp %0d", name, pc, p);
    end
    if (halted_zf !== ehz) begin
      n_fail++; $display("FAIL %s halted_zf got %b exp %b", name, halted_zf, ehz);
    end
    if (issue_seen != nissue) begin
      n_fail++; $display("FAIL %s issue_count got %0d exp %0d", name, issue_seen, nissue);
    end
    if (busy_seen != n - 1) begin
      n_fail++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_seen, n - 1);
    end
    clear_ctl();
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks += 6;
    if (instruction !== IDLE_W) begin n_fail++; $display("FAIL %s instruction got %h exp %h", name, instruction, IDLE_W); end
    if (issue !== 1'b0)     begin n_fail++; $display("FAIL %s issue got %b exp 0", name, issue); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL %s busy got %b exp 0", name, busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL %s done got %b exp 0", name, done); end
    if (pc !== 4'd0)        begin n_fail++; $display("FAIL %s pc got %0d exp 0", name, pc); end
    if (halted_zf !== 1'b0) begin n_fail++; $display("FAIL %s halted_zf got %b exp 0", name, halted_zf); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    load_word(4'd0, ADD_W);
    load_word(4'd1, SUB_W);
    load_word(4'd2, {4'hF, 15'($urandom)});
    run_check("basic", 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) load_word(4'(i), AND_W);
    run_check("full", 1'b0);
  endtask

  task automatic test_zf();
    for (int i = 0; i < 4; i++) load_word(4'(i), rand_word());
    zf_sched[4] = 1'b1;
    run_check("zf_stop", 1'b1);
    zf_sched[3] = 1'b1;
    run_check("zf_early", 1'b1);
  endtask

  task automatic test_reset_mid();
    load_word(4'd0, ADD_W);
    load_word(4'd1, SUB_W);
    load_word(4'd2, {4'hF, 15'd0});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (instruction !== SUB_W) begin
      n_fail++; $display("FAIL reset_mid pre_instr got %h exp %h", instruction, SUB_W);
    end
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_mid");
    @(negedge clk); reset = 1'b0;
    run_check("after_reset", 1'b0);
  endtask

  task automatic test_busy_ignore();
    inj_we_cyc = 3; inj_data = rand_word(); inj_st_cyc = 5;
    run_check("busy_ignore", 1'b0);
    load_word(4'd1, rand_word());
    run_check("done_write", 1'b0);
  endtask

  task automatic test_same_cycle();
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    same_we = 1'b1; same_addr = 4'd0; same_data = rand_word();
    run_check("same_cycle", 1'b0);
  endtask

  task automatic test_random();
    int hpos;
    for (int it = 0; it < 4; it++) begin
      hpos = $urandom_range(1, 20);
      for (int i = 0; i < 16; i++)
        load_word(4'(i), (i == hpos) ? {4'hF, 15'($urandom)} : rand_word());
      for (int c = 0; c < 128; c++) zf_sched[c] = ($urandom_range(0, 7) == 0);
      run_check("random", 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start = 1'b0; load_we = 1'b0; load_addr = '0; load_instr = '0;
    stop_on_zf = 1'b0; zf_in = 1'b0; reset = 1'b1;
    clear_ctl();
    test_reset();
    test_basic();
    test_full();
    test_zf();
    test_reset_mid();
    test_busy_ignore();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
